sys_ctrl_gen: RTL
=================

Name: sys_ctrl_gen

Overview:
Parametrised successor to the fixed 8-bit system controller. Sits in the REF_CLK domain between the synchronised UART RX bytes, the register file, the gated-clock ALU and the TX FIFO write port. Decodes multi-byte command frames and issues RF and ALU transactions. Returns read data and multi-word ALU results through the TX FIFO, honouring FIFO-full backpressure. Adds an inter-byte timeout that aborts partial frames.

Parameters:
DATA_WIDTH, 8, width of RX/TX words, RF data and ALU operands
ADDR_WIDTH, 4, RF address width
ALU_OUT_WIDTH, 16, ALU result width; result sent as NW = ceil(ALU_OUT_WIDTH/DATA_WIDTH) words
TIMEOUT_CYC, 1024, max CLK cycles between bytes of one frame; 0 disables timeout

Ports:
CLK  in  1  reference clock
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  synchronised received word
RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
RdData  in  DATA_WIDTH  RF read data
RdData_Valid  in  1  RF read data valid
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
OUT_Valid  in  1  ALU result valid
F_FULL  in  1  TX FIFO full
WrEN  out  1  RF write enable
RdEn  out  1  RF read enable
Address  out  ADDR_WIDTH  RF address
WrData  out  DATA_WIDTH  RF write data
ALU_EN  out  1  ALU enable
ALU_FUN  out  4  ALU function
CLK_EN  out  1  ALU clock-gate enable
TX_P_Data  out  DATA_WIDTH  FIFO write data
TX_D_VLD  out  1  FIFO write strobe
clk_div_en  out  1  clock divider enable
CMD_BUSY  out  1  high whenever state != IDLE
TIMEOUT_ERR  out  1  one-cycle pulse on frame abort

Behaviour:
- Reset (RST low, async): state IDLE; all outputs 0 except clk_div_en=1; timeout counter, response buffer and word index cleared.
- Commands (first byte, low 8 bits compared; upper bits must be 0): 0xAA RF write (addr, data); 0xBB RF read (addr); 0xCC ALU with operands (A, B, fun); 0xDD ALU without operands (fun). Any other first byte is unknown.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_SEND, ERR_SEND.
- RF write: address latched on the byte after 0xAA. The cycle after the data byte's RX_D_VLD: WrEN=1 for exactly one cycle, with Address/WrData valid. Then IDLE.
- RF read: the cycle after the address byte: RdEn=1 for one cycle; enter RD_WAIT. On RdData_Valid, load RdData into the response buffer with NW'=1; go to TX_SEND.
- 0xCC: operand A written to Address 0, B to Address 1. Each write is a one-cycle WrEN the cycle after its byte. The flow then continues as 0xDD.
- ALU_FUN: fun byte[3:0] latched to ALU_FUN. The next cycle: ALU_EN=1 for one cycle, CLK_EN=1; enter ALU_WAIT. CLK_EN stays 1 until the cycle OUT_Valid is seen, then drops to 0. ALU_OUT is captured with NW words; go to TX_SEND.
- TX_SEND: sends words least-significant first; the top word is zero-padded. In any cycle with F_FULL=0: TX_D_VLD=1, TX_P_Data=current word, index increments. With F_FULL=1: TX_D_VLD=0, hold. After the last word: IDLE.
- RX_D_VLD arriving in RD_WAIT, ALU_WAIT, TX_SEND or ERR_SEND is ignored (dropped).
- Timeout: counter clears on every accepted byte and counts in WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B and ALU_FUN. On reaching TIMEOUT_CYC: TIMEOUT_ERR pulses one cycle; return to IDLE, no RF/ALU side effect for the incomplete step. Waiting states (RD_WAIT, ALU_WAIT, TX_SEND) are never timed out.
- RX_D_VLD in the same cycle as timeout expiry: the timeout wins and the byte is dropped.
- Reset mid-operation: immediate return to reset values; a pending TX word is lost; CLK_EN drops.

Optional Feature:
SYS_CTRL_ERR_RESP_EN. Defined: an unknown command or a timeout enters ERR_SEND and writes one word 0xEE (zero-extended) to the FIFO under the same F_FULL rule, then IDLE. Undefined: unknown bytes are silently dropped in IDLE, the timeout only pulses TIMEOUT_ERR, and ERR_SEND is never entered.

Test Plan:
- RX 0xAA,0x05,0x3C -> a single WrEN pulse with Address=5, WrData=0x3C; CMD_BUSY low afterwards.
- RX 0xBB,0x05; RdData=0x3C with RdData_Valid 3 cycles after RdEn -> exactly one TX_D_VLD with TX_P_Data=0x3C.
- RX 0xCC,0x0A,0x03,0x00; ALU_OUT=0x000D with OUT_Valid -> writes A0=0x0A, A1=0x03; ALU_FUN=0; TX words 0x0D then 0x00; CLK_EN low after OUT_Valid.
- In the same ALU flow, hold F_FULL=1 for 10 cycles from TX_SEND entry -> no TX_D_VLD during that time; both words sent after release, in order.
- RX 0xAA,0x05 then idle for TIMEOUT_CYC cycles -> TIMEOUT_ERR pulse, no WrEN; a following 0x3C is treated as unknown (0xEE sent only with macro).
- Assert RST low during ALU_WAIT -> all outputs at reset values in the same cycle; 0xBB,0x01 then completes normally.

Source files
------------

// File: rtl/sys_ctrl_gen.sv
// rtl/sys_ctrl_gen.sv - UART command frame decoder driving RF, ALU and TX FIFO
// Optional macro SYS_CTRL_ERR_RESP_EN: unknown command / timeout send a 0xEE error word.
module sys_ctrl_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic                     F_FULL,
    output logic                     WrEN,
    output logic                     RdEn,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     CLK_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_Data,
    output logic                     TX_D_VLD,
    output logic                     clk_div_en,
    output logic                     CMD_BUSY,
    output logic                     TIMEOUT_ERR
);

    localparam int NW    = (ALU_OUT_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int BUF_W = NW * DATA_WIDTH;
    localparam int IDX_W = $clog2(NW) + 1;
    localparam int TW    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
        ALU_FUN_S, ALU_WAIT, TX_SEND, ERR_SEND
    } state_t;

`ifdef SYS_CTRL_ERR_RESP_EN
    localparam state_t ERR_DEST = ERR_SEND;
`else
    localparam state_t ERR_DEST = IDLE;
`endif

    state_t                state, state_nxt;
    logic                  in_frame, tmo_exp, rx_acc, last_word;
    logic [TW-1:0]         tmo_cnt;
    logic [BUF_W-1:0]      resp_buf;
    logic [IDX_W-1:0]      nw_r, idx;
    logic [DATA_WIDTH-1:0] cur_word;

    assign in_frame  = state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, ALU_FUN_S};
    assign tmo_exp   = (TIMEOUT_CYC != 0) && in_frame && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    // An expiring timeout swallows a byte arriving in the same cycle.
    assign rx_acc    = RX_D_VLD && !tmo_exp && (in_frame || state == IDLE);
    assign cur_word  = DATA_WIDTH'(resp_buf >> (idx * DATA_WIDTH));
    assign last_word = (idx == nw_r - 1'b1);

    assign TX_D_VLD   = (state == TX_SEND || state == ERR_SEND) && !F_FULL;
    assign TX_P_Data  = (state == ERR_SEND) ? DATA_WIDTH'(8'hEE) :
                        (state == TX_SEND)  ? cur_word : '0;
    assign CMD_BUSY   = (state != IDLE);
    assign clk_div_en = 1'b1;

    always_comb begin
        state_nxt = state;
        if (tmo_exp) begin
            state_nxt = ERR_DEST;
        end else begin
            case (state)
                IDLE: if (rx_acc) begin
                    if      (RX_P_DATA == DATA_WIDTH'(8'hAA)) state_nxt = WR_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(8'hBB)) state_nxt = RD_ADDR;
                    else if (RX_P_DATA == DATA_WIDTH'(8'hCC)) state_nxt = OP_A;
                    else if (RX_P_DATA == DATA_WIDTH'(8'hDD)) state_nxt = ALU_FUN_S;
                    else                                      state_nxt = ERR_DEST;
                end
                WR_ADDR:   if (rx_acc) state_nxt = WR_DATA;
                WR_DATA:   if (rx_acc) state_nxt = IDLE;
                RD_ADDR:   if (rx_acc) state_nxt = RD_WAIT;
                RD_WAIT:   if (RdData_Valid) state_nxt = TX_SEND;
                OP_A:      if (rx_acc) state_nxt = OP_B;
                OP_B:      if (rx_acc) state_nxt = ALU_FUN_S;
                ALU_FUN_S: if (rx_acc) state_nxt = ALU_WAIT;
                ALU_WAIT:  if (OUT_Valid) state_nxt = TX_SEND;
                TX_SEND:   if (!F_FULL && last_word) state_nxt = IDLE;
                ERR_SEND:  if (!F_FULL) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            resp_buf    <= '0;
            nw_r        <= '0;
            idx         <= '0;
            WrEN        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_EN      <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state       <= state_nxt;
            WrEN        <= 1'b0;
            RdEn        <= 1'b0;
            ALU_EN      <= 1'b0;
            TIMEOUT_ERR <= tmo_exp;
            if (!in_frame || rx_acc || tmo_exp) tmo_cnt <= '0;
            else                                tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
                WR_ADDR: if (rx_acc) Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                WR_DATA: if (rx_acc) begin
                    WrData <= RX_P_DATA;
                    WrEN   <= 1'b1;
                end
                RD_ADDR: if (rx_acc) begin
                    Address <= RX_P_DATA[ADDR_WIDTH-1:0];
                    RdEn    <= 1'b1;
                end
                RD_WAIT: if (RdData_Valid) begin
                    resp_buf <= BUF_W'(RdData);
                    nw_r     <= IDX_W'(1);
                    idx      <= '0;
                end
                OP_A: if (rx_acc) begin
                    Address <= '0;
                    WrData  <= RX_P_DATA;
                    WrEN    <= 1'b1;
                end
                OP_B: if (rx_acc) begin
                    Address <= ADDR_WIDTH'(1);
                    WrData  <= RX_P_DATA;
                    WrEN    <= 1'b1;
                end
                ALU_FUN_S: if (rx_acc) begin
                    ALU_FUN <= RX_P_DATA[3:0];
                    ALU_EN  <= 1'b1;
                    CLK_EN  <= 1'b1;
                end
                ALU_WAIT: if (OUT_Valid) begin
                    resp_buf <= BUF_W'(ALU_OUT);
                    nw_r     <= IDX_W'(NW);
                    idx      <= '0;
                    CLK_EN   <= 1'b0;
                end
                TX_SEND: if (!F_FULL) idx <= last_word ? '0 : idx + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
